fuzzify_mf_bank: RTL

Parametrised, multi-channel successor to the single combinational trapezoid membership function. Holds N_MF runtime-programmable trapezoid/triangle parameter sets and evaluates all of them for one crisp input sample. A single shared restoring divider is time-multiplexed across the sets. Sits between the input quantiser and the rule-evaluation stage of the fuzzy controller; signed Q(IN_W-1).0 in, unsigned Q1.(OUT_W-1) memberships out.

---
 rtl/fuzzify_mf_bank.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fuzzify_mf_bank.sv
// fuzzify_mf_bank: N_MF programmable trapezoid memberships sharing one restoring divider.
// Optional argmax tracker enabled by FUZZIFY_MF_BANK_ARGMAX_EN.
module fuzzify_mf_bank #(
    parameter int IN_W = 8,
    parameter int OUT_W = 16,
    parameter int N_MF = 4,
    localparam int IDX_W = N_MF > 1 ? $clog2(N_MF) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic signed [IN_W-1:0]  cfg_a,
    input  logic signed [IN_W-1:0]  cfg_b,
    input  logic signed [IN_W-1:0]  cfg_c,
    input  logic signed [IN_W-1:0]  cfg_d,
    output logic                    cfg_ready,
    output logic                    cfg_err,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_MF*OUT_W-1:0]   mu,
    output logic [IDX_W-1:0]        max_idx,
    output logic [OUT_W-1:0]        max_mu
);
    localparam int FRAC = OUT_W - 1;
    localparam int DW = IN_W + 1;
    localparam int CW = $clog2(OUT_W);

    typedef enum logic [1:0] {IDLE, CLASSIFY, DIVIDE, DONE} state_t;
    state_t state, state_n;

    logic signed [IN_W-1:0] pa [N_MF];
    logic signed [IN_W-1:0] pb [N_MF];
    logic signed [IN_W-1:0] pc [N_MF];
    logic signed [IN_W-1:0] pd [N_MF];
    logic signed [IN_W-1:0] xr;
    logic [OUT_W-1:0] mu_r [N_MF];
    logic [IDX_W-1:0] mf;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rem, den, num_c, den_c;
    logic [FRAC-1:0] q, q_n;
    logic plat;
    logic signed [DW-1:0] xe, ae, be, ce, de;
    logic zero, rise, flat, fall, ge, last, cfg_ok;
    logic [DW:0] sh, diff;
    logic [DW-1:0] rem_n;
    logic [OUT_W-1:0] mu_val;

    assign cfg_ready = state == IDLE;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign cfg_ok = cfg_ready && cfg_a <= cfg_b && cfg_b <= cfg_c && cfg_c <= cfg_d
                    && 32'(cfg_idx) < N_MF;
    assign last = cnt == CW'(FRAC - 1);

    // Breakpoint differences need one extra bit so x-a and d-x never overflow.
    always_comb begin
        xe = {xr[IN_W-1], xr};
        ae = {pa[mf][IN_W-1], pa[mf]};
        be = {pb[mf][IN_W-1], pb[mf]};
        ce = {pc[mf][IN_W-1], pc[mf]};
        de = {pd[mf][IN_W-1], pd[mf]};
        zero = xe < ae || xe > de;
        rise = !zero && xe < be;
        flat = !zero && !rise && xe <= ce;
        fall = !zero && !rise && !flat;
        num_c = rise ? DW'(xe - ae) : fall ? DW'(de - xe) : '0;
        den_c = rise ? DW'(be - ae) : fall ? DW'(de - ce) : DW'(1);
    end

    // One restoring step; the remainder starts as num, which is already below den.
    always_comb begin
        sh = {rem, 1'b0};
        diff = sh - {1'b0, den};
        ge = sh >= {1'b0, den};
        rem_n = ge ? diff[DW-1:0] : sh[DW-1:0];
        q_n = FRAC'({q, ge});
        mu_val = plat ? {1'b0, {FRAC{1'b1}}} : {1'b0, q_n};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = in_valid ? CLASSIFY : IDLE;
            CLASSIFY: state_n = DIVIDE;
            DIVIDE:   state_n = !last ? DIVIDE : mf == IDX_W'(N_MF - 1) ? DONE : CLASSIFY;
            DONE:     state_n = out_ready ? IDLE : DONE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MF; i++) begin
                pa[i] <= '0;
                pb[i] <= '0;
                pc[i] <= '0;
                pd[i] <= '0;
                mu_r[i] <= '0;
            end
            cfg_err <= 1'b0;
            xr <= '0;
            mf <= '0;
            cnt <= '0;
            rem <= '0;
            den <= '0;
            q <= '0;
            plat <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                pa[cfg_idx] <= cfg_a;
                pb[cfg_idx] <= cfg_b;
                pc[cfg_idx] <= cfg_c;
                pd[cfg_idx] <= cfg_d;
            end
            case (state)
                IDLE: if (in_valid) begin
                    xr <= x;
                    mf <= '0;
                end
                CLASSIFY: begin
                    rem <= num_c;
                    den <= den_c;
                    plat <= flat;
                    cnt <= '0;
                end
                DIVIDE: begin
                    rem <= rem_n;
                    q <= q_n;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        mu_r[mf] <= mu_val;
                        mf <= mf + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N_MF; g++) begin : g_mu
        assign mu[g*OUT_W +: OUT_W] = mu_r[g];
    end

`ifdef FUZZIFY_MF_BANK_ARGMAX_EN
    logic [IDX_W-1:0] mx_idx;
    logic [OUT_W-1:0] mx_mu;
    // Strict compare keeps the lowest index on ties.
    always_ff @(posedge clk)
        if (!rst_n) begin
            mx_idx <= '0;
            mx_mu <= '0;
        end else if (state == DIVIDE && last && (mf == '0 || mu_val > mx_mu)) begin
            mx_idx <= mf;
            mx_mu <= mu_val;
        end
    assign max_idx = mx_idx;
    assign max_mu = mx_mu;
`else
    assign max_idx = '0;
    assign max_mu = '0;
`endif
endmodule
